// File: rtl/alu_arb_ctrl.sv
// alu_arb_ctrl: shares one combinational ALU between two requesters.
// Requests are arbitrated round-robin in IDLE, the winning operation is
// latched and presented to the ALU for exactly one EXEC cycle, and the
// captured result is held in RESP until the consumer takes it.
module alu_arb_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic             req1_valid,
    output logic             req0_ready,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req0_opa,
    input  logic [WIDTH-1:0] req0_opb,
    input  logic [WIDTH-1:0] req1_opa,
    input  logic [WIDTH-1:0] req1_opb,
    input  logic [2:0]       req0_sel,
    input  logic [2:0]       req1_sel,
    output logic [WIDTH-1:0] alu_opa,
    output logic [WIDTH-1:0] alu_opb,
    output logic [2:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_res,
    input  logic             alu_z,
    input  logic             alu_c,
    input  logic             alu_v,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_res,
    output logic             rsp_z,
    output logic             rsp_c,
    output logic             rsp_v,
    output logic             rsp_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;

    // r_prio names the requester that wins when both are valid; it is the
    // complement of the last granted index, so req0 wins the first tie.
    logic             r_prio;
    logic [WIDTH-1:0] r_opa;
    logic [WIDTH-1:0] r_opb;
    logic [2:0]       r_sel;
    logic             r_id;

    logic [WIDTH-1:0] r_rsp_res;
    logic             r_rsp_id;
    logic             r_rsp_z;
    logic             r_rsp_c;
    logic             r_rsp_v;
    logic             r_rsp_err;

    logic w_gnt0;
    logic w_gnt1;
    logic w_accept;
    logic w_illegal;

    assign w_accept  = w_gnt0 | w_gnt1;
    assign w_illegal = (r_sel > 3'd4);

    // Round-robin grant; only offered in IDLE and never while reset is held.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (r_state == ST_IDLE && !rst) begin
            if (req0_valid && (!req1_valid || (r_prio == 1'b0))) begin
                w_gnt0 = 1'b1;
            end else if (req1_valid) begin
                w_gnt1 = 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state: one accept starts a fixed EXEC cycle, RESP waits for handshake.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept)  w_next = ST_EXEC;
            ST_EXEC: w_next = ST_RESP;
            ST_RESP: if (rsp_ready) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Outputs: grants, ALU drive (zeroed unless a legal op is executing), response valid.
    always_comb begin
        req0_ready = w_gnt0;
        req1_ready = w_gnt1;
        alu_opa    = '0;
        alu_opb    = '0;
        alu_sel    = 3'b000;
        rsp_valid  = 1'b0;
        case (r_state)
            ST_EXEC: begin
                if (!w_illegal) begin
                    alu_opa = r_opa;
                    alu_opb = r_opb;
                    alu_sel = r_sel;
                end
            end
            ST_RESP: rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // Operation latch on accept and result capture at the end of EXEC.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prio    <= 1'b0;
            r_opa     <= '0;
            r_opb     <= '0;
            r_sel     <= 3'b000;
            r_id      <= 1'b0;
            r_rsp_res <= '0;
            r_rsp_id  <= 1'b0;
            r_rsp_z   <= 1'b0;
            r_rsp_c   <= 1'b0;
            r_rsp_v   <= 1'b0;
            r_rsp_err <= 1'b0;
        end else begin
            if (w_accept) begin
                r_prio <= ~w_gnt1;
                r_id   <= w_gnt1;
                r_opa  <= w_gnt1 ? req1_opa : req0_opa;
                r_opb  <= w_gnt1 ? req1_opb : req0_opb;
                r_sel  <= w_gnt1 ? req1_sel : req0_sel;
            end
            if (r_state == ST_EXEC) begin
                r_rsp_id <= r_id;
                if (w_illegal) begin
                    r_rsp_res <= '0;
                    r_rsp_z   <= 1'b0;
                    r_rsp_c   <= 1'b0;
                    r_rsp_v   <= 1'b0;
                    r_rsp_err <= 1'b1;
                end else begin
                    r_rsp_res <= alu_res;
                    r_rsp_z   <= alu_z;
                    r_rsp_c   <= alu_c;
                    r_rsp_v   <= alu_v;
                    r_rsp_err <= 1'b0;
                end
            end
        end
    end

    assign rsp_res = r_rsp_res;
    assign rsp_id  = r_rsp_id;
    assign rsp_z   = r_rsp_z;
    assign rsp_c   = r_rsp_c;
    assign rsp_v   = r_rsp_v;
    assign rsp_err = r_rsp_err;

endmodule
